reg_load_arbiter: RTL and testbench
===================================

// Module: reg_load_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one N-bit load register (Clk/Clr/Ld/I/Q
//  register block) between NREQ requesters. Drives the register's Clr, Ld and I
//  inputs and returns a one-cycle grant pulse to each requester.
//  Sits between requesting datapath units and the shared register instance.
// PARAMETERS
//  N     12  data width, equal to the shared register width
//  NREQ   4  number of requesters (2..8)
// PORTS
//  Clk     in   1         system clock, all state changes on posedge
//  Rst_n   in   1         asynchronous active-low reset
//  Req     in   NREQ      level load request per requester, held until granted
//  Data    in   N*NREQ    load data, requester k at bits [k*N +: N]
//  ClrReq  in   1         level clear request, held until ClrAck
//  Gnt     out  NREQ      one-hot grant pulse, coincident with Ld
//  Ld      out  1         load strobe to the shared register
//  I       out  N         load data to the shared register
//  Clr     out  1         clear strobe to the shared register
//  ClrAck  out  1         clear accepted, coincident with Clr
//  Busy    out  1         high in any state other than IDLE
// BEHAVIOUR
//  - Rst_n=0: immediately state=IDLE, Gnt=0, Ld=0, I=0, Clr=0, ClrAck=0,
//    Busy=0, rr pointer=0 (requester 0 highest priority). Applies mid-operation.
//  - All outputs registered. FSM states IDLE, CLEAR, LOAD, WAIT.
//  - IDLE: ClrReq=1 -> CLEAR (clear wins over any Req in the same cycle).
//    Else any Req -> LOAD. Winner is chosen from Req at that edge, and
//    Data[winner] is captured into I at that edge. Else stay IDLE.
//  - CLEAR (1 cycle): Clr=1, ClrAck=1, Ld=0 -> WAIT.
//  - LOAD (1 cycle): Ld=1, Gnt=onehot(winner), I=captured data -> WAIT;
//    the rr pointer becomes winner+1 mod NREQ.
//  - WAIT (1 cycle): all strobes 0, so requesters drop Req/ClrReq -> IDLE.
//    A request seen in WAIT is ignored. Max throughput is 1 op per 3 cycles.
//  - Latency: Req rising at edge t gives Ld/Gnt high for cycle t+1.
//  - Round-robin: search order is ptr, ptr+1, ... NREQ-1, 0, ... (wrap).
//  - Req dropped before arbitration: no grant. ClrReq arriving in
//    LOAD/WAIT is served at the next IDLE.
//  - Outside LOAD: Gnt=0, Ld=0, I holds its last value.
//  - Gnt, Ld, Clr are never high together except Gnt with Ld.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: fixed priority, lowest asserted index wins,
//    rr pointer removed/unused.
//  Undefined (default): round-robin as above.
// STRUCTURE
//  Package reg_arb_pkg: state localparams (IDLE=2'd0, CLEAR=2'd1, LOAD=2'd2,
//    WAIT=2'd3) and the max NREQ constant.
//  Sub-module rr_pick: combinational one-hot picker (Req, ptr -> onehot, index).
//  Top: FSM, pointer, output registers.
// TESTING
//  1 Reset: Rst_n=0 mid-LOAD -> all outputs 0 at once; after release,
//    Req=4'b1111 -> Gnt=4'b0001.
//  2 Single: Req=4'b0100, Data[2]=12'hABC -> next cycle Ld=1, Gnt=4'b0100,
//    I=12'hABC; Ld=0 in the following cycle.
//  3 Round-robin: Req=4'b1111 held and re-raised after each Gnt ->
//    Gnt 0001,0010,0100,1000,0001, one every 3 cycles.
//  4 Clear priority: ClrReq=1 and Req=4'b0001 at the same edge -> Clr/ClrAck
//    first, then WAIT, then Gnt=4'b0001 with Ld=1.
//  5 Wrap/ptr: grant 3 then Req=4'b1001 -> Gnt=4'b0001. With ARB_FIXED_PRIO_EN,
//    after grant 0 with Req=4'b1001 -> Gnt=4'b0001 again.
//  6 Idle: Req=0, ClrReq=0 for 10 cycles -> Busy=0, Ld=Clr=0, I unchanged.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-load arbiter.
package reg_arb_pkg;

  // Sequencer states; every operation is a one-cycle strobe followed by one WAIT cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int unsigned MIN_NREQ = 2;
  localparam int unsigned MAX_NREQ = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   index,
  output logic            valid
);

  logic [PW:0]   pos;
  logic [PW-1:0] slot;

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    pos    = '0;
    slot   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      pos = (PW+1)'(ptr) + (PW+1)'(k);
      if (pos >= (PW+1)'(NREQ)) pos = pos - (PW+1)'(NREQ);
      slot = pos[PW-1:0];
      if (!valid && req[slot]) begin
        valid        = 1'b1;
        index        = slot;
        onehot[slot] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// Arbiter/sequencer sharing one load register (Clr/Ld/I) between NREQ requesters.
// Optional build macro ARB_FIXED_PRIO_EN: lowest asserted index always wins and the
// round-robin pointer is removed; default build is round-robin.
module reg_load_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned N    = 12,
  parameter int unsigned NREQ = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [NREQ-1:0]   Req,
  input  logic [N*NREQ-1:0] Data,
  input  logic              ClrReq,
  output logic [NREQ-1:0]   Gnt,
  output logic              Ld,
  output logic [N-1:0]      I,
  output logic              Clr,
  output logic              ClrAck,
  output logic              Busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            ld_nxt;
  logic            clr_nxt;
  logic [N-1:0]    i_nxt;

  logic [PW-1:0]   search_ptr;
  logic [NREQ-1:0] pick_onehot;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (Req),
    .ptr    (search_ptr),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .valid  (pick_valid)
  );

`ifdef ARB_FIXED_PRIO_EN
  // Search always starts at requester 0.
  assign search_ptr = '0;
`else
  logic [PW-1:0] rr_ptr;

  // Pointer moves past the winner at the edge the load is accepted.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rr_ptr <= '0;
    end else if (state == IDLE && !ClrReq && pick_valid) begin
      rr_ptr <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
    end
  end

  assign search_ptr = rr_ptr;
`endif

  // Next state and next output values; strobes are computed one cycle ahead and registered.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = '0;
    ld_nxt    = 1'b0;
    clr_nxt   = 1'b0;
    i_nxt     = I;
    case (state)
      IDLE: begin
        if (ClrReq) begin
          state_nxt = CLEAR;
          clr_nxt   = 1'b1;
        end else if (pick_valid) begin
          state_nxt = LOAD;
          ld_nxt    = 1'b1;
          gnt_nxt   = pick_onehot;
          i_nxt     = Data[32'(pick_idx) * N +: N];
        end
      end
      CLEAR:   state_nxt = WAIT;
      LOAD:    state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= IDLE;
      Gnt    <= '0;
      Ld     <= 1'b0;
      I      <= '0;
      Clr    <= 1'b0;
      ClrAck <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      Gnt    <= gnt_nxt;
      Ld     <= ld_nxt;
      I      <= i_nxt;
      Clr    <= clr_nxt;
      ClrAck <= clr_nxt;
      Busy   <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Self-checking bench for reg_load_arbiter: directed scenarios plus random traffic
// compared each cycle against an operation-level reference model.
module tb_reg_load_arbiter;

  localparam int N    = 12;
  localparam int NREQ = 4;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic [NREQ-1:0]   Req;
  logic [N*NREQ-1:0] Data;
  logic              ClrReq;
  logic [NREQ-1:0]   Gnt;
  logic              Ld;
  logic [N-1:0]      I;
  logic              Clr;
  logic              ClrAck;
  logic              Busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: cycles until the next arbitration opportunity, rr pointer, expected outputs.
  int              m_cool;
  int              m_ptr;
  logic [NREQ-1:0] m_gnt;
  logic            m_ld;
  logic            m_clr;
  logic [N-1:0]    m_i;

  reg_load_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Req    (Req),
    .Data   (Data),
    .ClrReq (ClrReq),
    .Gnt    (Gnt),
    .Ld     (Ld),
    .I      (I),
    .Clr    (Clr),
    .ClrAck (ClrAck),
    .Busy   (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cool = 0;
    m_ptr  = 0;
    m_gnt  = '0;
    m_ld   = 1'b0;
    m_clr  = 1'b0;
    m_i    = '0;
  endtask

  // One operation takes three cycles (strobe, wait, idle) before the next can be accepted.
  task automatic model_edge();
    int w;
    m_gnt = '0;
    m_ld  = 1'b0;
    m_clr = 1'b0;
    if (m_cool > 0) begin
      m_cool--;
    end else if (ClrReq) begin
      m_clr  = 1'b1;
      m_cool = 2;
    end else if (Req != '0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && Req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      m_ld     = 1'b1;
      m_gnt    = NREQ'(1) << w;
      m_i      = Data[w*N +: N];
`ifndef ARB_FIXED_PRIO_EN
      m_ptr    = (w + 1) % NREQ;
`endif
      m_cool   = 2;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".gnt"},    32'(Gnt),    32'(m_gnt));
    chk({tag, ".ld"},     32'(Ld),     32'(m_ld));
    chk({tag, ".i"},      32'(I),      32'(m_i));
    chk({tag, ".clr"},    32'(Clr),    32'(m_clr));
    chk({tag, ".clrack"}, 32'(ClrAck), 32'(m_clr));
    chk({tag, ".busy"},   32'(Busy),   32'(m_cool > 0));
  endtask

  task automatic cycle(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 5 && m_cool > 0; k++) cycle(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".gnt"},    32'(Gnt),    32'h0);
    chk({tag, ".ld"},     32'(Ld),     32'h0);
    chk({tag, ".i"},      32'(I),      32'h0);
    chk({tag, ".clr"},    32'(Clr),    32'h0);
    chk({tag, ".clrack"}, 32'(ClrAck), 32'h0);
    chk({tag, ".busy"},   32'(Busy),   32'h0);
  endtask

  initial begin
    int              gap;
    logic            seen;
    logic [N-1:0]    held_i;
    logic [NREQ-1:0] exp_gnt;

    Rst_n  = 1'b0;
    Req    = '0;
    Data   = '0;
    ClrReq = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_all_zero("reset");
    @(negedge Clk);
    Rst_n = 1'b1;

    // Single request from requester 2
    Req  = 4'b0100;
    Data = '0;
    Data[2*N +: N] = 12'hABC;
    cycle("single");
    chk("single.ld_const",  32'(Ld),  32'h1);
    chk("single.gnt_const", 32'(Gnt), 32'h4);
    chk("single.i_const",   32'(I),   32'hABC);
    Req = '0;
    cycle("single_after");
    chk("single.ld_drop", 32'(Ld), 32'h0);
    drain("single_drain");

    // Asynchronous reset in the middle of a load
    Req  = 4'b0010;
    Data = {12'h444, 12'h333, 12'h222, 12'h111};
    cycle("pre_reset");
    chk("pre_reset.ld", 32'(Ld), 32'h1);
    Rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("midreset");
    Req = 4'b1111;
    @(negedge Clk);
    Rst_n = 1'b1;
    cycle("post_reset");
    chk("post_reset.gnt", 32'(Gnt), 32'h1);

    // Round-robin with all requesters held
    for (int g = 1; g <= 4; g++) begin
      gap  = 0;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        cycle("rr");
        gap++;
        if (Ld) seen = 1'b1;
      end
      chk("rr.seen", 32'(seen), 32'h1);
      chk("rr.gap",  32'(gap),  32'h3);
`ifdef ARB_FIXED_PRIO_EN
      exp_gnt = 4'b0001;
`else
      exp_gnt = NREQ'(1) << (g % NREQ);
`endif
      chk("rr.gnt", 32'(Gnt), 32'(exp_gnt));
    end
    Req = '0;
    drain("rr_drain");

    // Clear wins over a simultaneous load request
    ClrReq = 1'b1;
    Req    = 4'b0001;
    cycle("clr");
    chk("clr.clr",    32'(Clr),    32'h1);
    chk("clr.clrack", 32'(ClrAck), 32'h1);
    chk("clr.ld",     32'(Ld),     32'h0);
    ClrReq = 1'b0;
    seen   = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      cycle("clr_then_load");
      if (Ld) seen = 1'b1;
    end
    chk("clr.load_seen", 32'(seen), 32'h1);
    chk("clr.load_gnt",  32'(Gnt),  32'h1);
    Req = '0;
    drain("clr_drain");

    // Pointer wrap: grant requester 3, then 0 and 3 compete
    Req = 4'b1000;
    cycle("wrap3");
    chk("wrap3.gnt", 32'(Gnt), 32'h8);
    Req = '0;
    drain("wrap3_drain");
    Req = 4'b1001;
    cycle("wrap0");
    chk("wrap0.gnt", 32'(Gnt), 32'h1);
    Req = '0;
    drain("wrap0_drain");
    Req = 4'b1001;
    cycle("after0");
`ifdef ARB_FIXED_PRIO_EN
    chk("after0.gnt", 32'(Gnt), 32'h1);
`else
    chk("after0.gnt", 32'(Gnt), 32'h8);
`endif
    Req = '0;
    drain("after0_drain");

    // Idle: nothing requested for 10 cycles
    held_i = I;
    Data   = {12'hFFF, 12'hEEE, 12'hDDD, 12'hCCC};
    for (int k = 0; k < 10; k++) begin
      cycle("idle");
      chk("idle.busy", 32'(Busy), 32'h0);
      chk("idle.i",    32'(I),    32'(held_i));
    end

    // Random traffic checked against the model
    for (int k = 0; k < 300; k++) begin
      @(negedge Clk);
      Req    = NREQ'($urandom);
      ClrReq = ($urandom_range(0, 7) == 0);
      Data   = {$urandom, $urandom};
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
